// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem.
// Holds the FPR write-back source tag and the write-back payload struct.
package fpu_ss_pkg;

    localparam int unsigned FPR_FLEN = 32;

    typedef enum logic [1:0] {
        WbLsu = 2'd0,
        WbFpu = 2'd1,
        WbVec = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [4:0]          addr;
        logic [FPR_FLEN-1:0] data;
    } fpr_wb_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Small FIFO of FPR write-back entries.
// Buffers LSU results that could not be written in their arrival cycle.
module fpu_ss_wb_fifo
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  fpr_wb_t          data_i,
    output fpr_wb_t          head_o,
    output logic [CNT_W-1:0] cnt_o
);

    fpr_wb_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage: no reset needed, occupancy tracking decides what is live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= ptr_next(wr_q);
            end
            if (pop_i) begin
                rd_q <= ptr_next(rd_q);
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign head_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fpu_ss_fpr_wb_arbiter.sv
// Single FPR write-port arbiter for LSU, FPnew and vector-unit results.
// LSU has priority; a starvation limiter occasionally yields to FPU/VEC.
module fpu_ss_fpr_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned FLEN          = FPR_FLEN,
    parameter  int unsigned LSU_BUF_DEPTH = 2,
    parameter  int unsigned STARVE_LIMIT  = 4,
    localparam int unsigned CNT_W         = $clog2(LSU_BUF_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lsu_valid_i,
    input  logic [4:0]       lsu_addr_i,
    input  logic [FLEN-1:0]  lsu_data_i,
    input  logic             fpu_valid_i,
    output logic             fpu_ready_o,
    input  logic [4:0]       fpu_addr_i,
    input  logic [FLEN-1:0]  fpu_data_i,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [4:0]       vec_addr_i,
    input  logic [FLEN-1:0]  vec_data_i,
    output logic             fpr_we_o,
    output logic [4:0]       fpr_waddr_o,
    output logic [FLEN-1:0]  fpr_wdata_o,
    output logic [1:0]       fpr_wsrc_o,
    output logic [CNT_W-1:0] lsu_buf_cnt_o
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0]  starve_q;
    wb_src_e          rr_q;
    logic [CNT_W-1:0] cnt;
    fpr_wb_t          head;
    fpr_wb_t          lsu_entry;

    logic lsu_pend;
    logic oth_pend;
    logic yield;
    logic lsu_gnt;
    logic oth_gnt;
    logic pop;
    logic byp;
    logic push;
    logic fpu_gnt;
    logic vec_gnt;

    assign lsu_entry.addr = lsu_addr_i;
    assign lsu_entry.data = lsu_data_i;

    // Grant selection: LSU class first unless the limiter forces a yield.
    always_comb begin
        lsu_pend = lsu_valid_i | (cnt != '0);
        oth_pend = fpu_valid_i | vec_valid_i;
        yield    = oth_pend
                 & (starve_q == SC_W'(STARVE_LIMIT))
                 & (cnt < CNT_W'(LSU_BUF_DEPTH));
        lsu_gnt  = lsu_pend & ~yield;
        oth_gnt  = ~lsu_gnt & oth_pend;
        pop      = lsu_gnt & (cnt != '0);
        byp      = lsu_gnt & (cnt == '0);
        push     = lsu_valid_i & ~byp;
        fpu_gnt  = oth_gnt & fpu_valid_i & (~vec_valid_i | (rr_q == WbFpu));
        vec_gnt  = oth_gnt & ~fpu_gnt;
    end

    fpu_ss_wb_fifo #(
        .DEPTH (LSU_BUF_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (lsu_entry),
        .head_o (head),
        .cnt_o  (cnt)
    );

    // Write-port mux driven by the one-hot grant.
    always_comb begin
        fpr_we_o    = 1'b0;
        fpr_waddr_o = '0;
        fpr_wdata_o = '0;
        fpr_wsrc_o  = WbLsu;
        unique case (1'b1)
            pop: begin
                fpr_we_o    = 1'b1;
                fpr_waddr_o = head.addr;
                fpr_wdata_o = head.data;
            end
            byp: begin
                fpr_we_o    = 1'b1;
                fpr_waddr_o = lsu_addr_i;
                fpr_wdata_o = lsu_data_i;
            end
            fpu_gnt: begin
                fpr_we_o    = 1'b1;
                fpr_waddr_o = fpu_addr_i;
                fpr_wdata_o = fpu_data_i;
                fpr_wsrc_o  = WbFpu;
            end
            vec_gnt: begin
                fpr_we_o    = 1'b1;
                fpr_waddr_o = vec_addr_i;
                fpr_wdata_o = vec_data_i;
                fpr_wsrc_o  = WbVec;
            end
            default: ;
        endcase
    end

    assign fpu_ready_o   = fpu_gnt;
    assign vec_ready_o   = vec_gnt;
    assign lsu_buf_cnt_o = cnt;

    // Starvation counter and FPU/VEC round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
            rr_q     <= WbFpu;
        end else begin
            if (!oth_pend || oth_gnt) begin
                starve_q <= '0;
            end else if (lsu_gnt && (starve_q != SC_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + SC_W'(1);
            end
            if (fpu_gnt) begin
                rr_q <= WbVec;
            end else if (vec_gnt) begin
                rr_q <= WbFpu;
            end
        end
    end

    // A full FIFO always forces an LSU-class pop, so it can never overflow.
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (cnt == CNT_W'(LSU_BUF_DEPTH)))
    );

endmodule

// File: tb/tb_fpu_ss_fpr_wb_arbiter.sv
// Directed bench for the FPR write-back arbiter.
// Expected writes are queued by the stimulus and popped by a monitor.
module tb_fpu_ss_fpr_wb_arbiter;
    import fpu_ss_pkg::*;

    localparam int unsigned FLEN  = 32;
    localparam int unsigned CNT_W = 2;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             lsu_valid;
    logic [4:0]       lsu_addr;
    logic [FLEN-1:0]  lsu_data;
    logic             fpu_valid;
    logic             fpu_ready;
    logic [4:0]       fpu_addr;
    logic [FLEN-1:0]  fpu_data;
    logic             vec_valid;
    logic             vec_ready;
    logic [4:0]       vec_addr;
    logic [FLEN-1:0]  vec_data;
    logic             fpr_we;
    logic [4:0]       fpr_waddr;
    logic [FLEN-1:0]  fpr_wdata;
    logic [1:0]       fpr_wsrc;
    logic [CNT_W-1:0] buf_cnt;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    fpu_ss_fpr_wb_arbiter #(
        .FLEN          (FLEN),
        .LSU_BUF_DEPTH (2),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .lsu_valid_i   (lsu_valid),
        .lsu_addr_i    (lsu_addr),
        .lsu_data_i    (lsu_data),
        .fpu_valid_i   (fpu_valid),
        .fpu_ready_o   (fpu_ready),
        .fpu_addr_i    (fpu_addr),
        .fpu_data_i    (fpu_data),
        .vec_valid_i   (vec_valid),
        .vec_ready_o   (vec_ready),
        .vec_addr_i    (vec_addr),
        .vec_data_i    (vec_data),
        .fpr_we_o      (fpr_we),
        .fpr_waddr_o   (fpr_waddr),
        .fpr_wdata_o   (fpr_wdata),
        .fpr_wsrc_o    (fpr_wsrc),
        .lsu_buf_cnt_o (buf_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic fv, input logic [4:0] fa, input logic [31:0] fd,
        input logic vv, input logic [4:0] va, input logic [31:0] vd
    );
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        fpu_valid = fv; fpu_addr = fa; fpu_data = fd;
        vec_valid = vv; vec_addr = va; vec_data = vd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic exp_w(input logic [1:0] s, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.src  = s;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic chk_cnt(input int e, input string nm);
        checks++;
        if (buf_cnt !== CNT_W'(e)) begin
            failures++;
            $display("FAIL %s cnt got=%0d exp=%0d", nm, buf_cnt, e);
        end
    endtask

    // Monitor: every DUT write must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (fpr_we === 1'b1) begin
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h src=%0d",
                         fpr_waddr, fpr_wdata, fpr_wsrc);
            end else begin
                e = q.pop_front();
                if (fpr_waddr !== e.addr || fpr_wdata !== e.data ||
                    fpr_wsrc !== e.src ||
                    fpu_ready !== (e.src == WbFpu) ||
                    vec_ready !== (e.src == WbVec)) begin
                    failures++;
                    $display("FAIL write got a=%0d d=%h s=%0d fr=%b vr=%b exp a=%0d d=%h s=%0d",
                             fpr_waddr, fpr_wdata, fpr_wsrc, fpu_ready, vec_ready,
                             e.addr, e.data, e.src);
                end
            end
        end else if (fpr_we !== 1'b0 || fpu_ready !== 1'b0 || vec_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs got we=%b fr=%b vr=%b exp 0 0 0",
                     fpr_we, fpu_ready, vec_ready);
        end
    end

    initial begin
        rst = 1'b1;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
        fpu_valid = 0; fpu_addr = 0; fpu_data = 0;
        vec_valid = 0; vec_addr = 0; vec_data = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt(0, "reset_cnt");

        // Solo sources
        exp_w(WbLsu, 3, 32'hA);
        cyc(1, 3, 32'hA, 0, 0, 0, 0, 0, 0);
        chk_cnt(0, "solo_lsu_cnt");
        exp_w(WbFpu, 5, 32'hF0);
        cyc(0, 0, 0, 1, 5, 32'hF0, 0, 0, 0);
        exp_w(WbVec, 7, 32'hE0);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'hE0);
        idle();

        // Round-robin between FPU and VEC
        exp_w(WbFpu, 10, 32'hF0);
        exp_w(WbVec, 20, 32'hE0);
        exp_w(WbFpu, 11, 32'hF1);
        exp_w(WbVec, 21, 32'hE1);
        exp_w(WbFpu, 12, 32'hF2);
        cyc(0, 0, 0, 1, 10, 32'hF0, 1, 20, 32'hE0);
        cyc(0, 0, 0, 1, 11, 32'hF1, 1, 20, 32'hE0);
        cyc(0, 0, 0, 1, 11, 32'hF1, 1, 21, 32'hE1);
        cyc(0, 0, 0, 1, 12, 32'hF2, 1, 21, 32'hE1);
        cyc(0, 0, 0, 1, 12, 32'hF2, 0, 0, 0);
        idle();

        // Conflict: LSU wins, FPU follows
        exp_w(WbLsu, 1, 32'h11);
        exp_w(WbFpu, 2, 32'h22);
        cyc(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0);
        chk_cnt(0, "conflict_cnt");
        cyc(0, 0, 0, 1, 2, 32'h22, 0, 0, 0);
        idle();

        // Starvation limiter with in-order LSU retirement
        for (int i = 0; i < 4; i++) exp_w(WbLsu, 5'(i), 32'h100 + i);
        exp_w(WbFpu, 9, 32'h99);
        for (int i = 4; i < 10; i++) exp_w(WbLsu, 5'(i), 32'h100 + i);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) chk_cnt(1, "starve_push_cnt");
            cyc(1, 5'(i), 32'h100 + i, (i <= 4), 9, 32'h99, 0, 0, 0);
        end
        chk_cnt(1, "starve_tail_cnt");
        idle();
        chk_cnt(0, "starve_drain_cnt");
        idle();

        // Full FIFO suppresses the yield
        for (int i = 0; i < 4; i++) exp_w(WbLsu, 5'(16 + i), 32'h200 + i);
        exp_w(WbFpu, 30, 32'h300);
        for (int i = 4; i < 8; i++) exp_w(WbLsu, 5'(16 + i), 32'h200 + i);
        exp_w(WbFpu, 30, 32'h300);
        for (int i = 8; i < 14; i++) exp_w(WbLsu, 5'(16 + i), 32'h200 + i);
        exp_w(WbFpu, 30, 32'h300);
        exp_w(WbLsu, 30, 32'h20E);
        exp_w(WbFpu, 30, 32'h300);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) chk_cnt(2, "full_before_cnt");
            cyc(1, 5'(16 + i), 32'h200 + i, 1, 30, 32'h300, 0, 0, 0);
        end
        chk_cnt(2, "full_hold_cnt");
        cyc(0, 0, 0, 1, 30, 32'h300, 0, 0, 0);
        chk_cnt(1, "full_pop_cnt");
        cyc(0, 0, 0, 1, 30, 32'h300, 0, 0, 0);
        cyc(0, 0, 0, 1, 30, 32'h300, 0, 0, 0);
        cyc(0, 0, 0, 1, 30, 32'h300, 0, 0, 0);
        idle();
        chk_cnt(0, "full_drain_cnt");

        // Reset with two buffered entries; only the head shown in the reset cycle
        for (int i = 0; i < 4; i++) exp_w(WbLsu, 5'(i), 32'h400 + i);
        exp_w(WbFpu, 29, 32'h500);
        for (int i = 4; i < 8; i++) exp_w(WbLsu, 5'(i), 32'h400 + i);
        exp_w(WbFpu, 29, 32'h500);
        exp_w(WbLsu, 8, 32'h408);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 5'(i), 32'h400 + i, 1, 29, 32'h500, 0, 0, 0);
        end
        chk_cnt(2, "rst_before_cnt");
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk_cnt(0, "rst_after_cnt");
        idle();
        idle();
        chk_cnt(0, "rst_idle_cnt");

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes got_left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_ss_fpr_wb_arbiter.md
Name: fpu_ss_fpr_wb_arbiter

Overview:
- Owns the single write port of the FP register file (FPR) and arbitrates among three sources: LSU load results, FPnew results and Vicuna vector-unit scalar results.
- Replaces the "never simultaneous" assumptions with real arbitration. The LSU result path cannot be back-pressured, so it gets priority, plus a small skid FIFO that lets a starvation limiter occasionally yield to the other two sources.
- Sits between the FPU subsystem controller (scoreboard-clear and forwarding consumers) and the FPR.

Parameters:
- FLEN, 32, FPR data width.
- LSU_BUF_DEPTH, 2, LSU skid FIFO entries; must be >= 1.
- STARVE_LIMIT, 4, consecutive LSU-class grants allowed while FPU/VEC is pending; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- lsu_valid_i  in  1  load result valid; no ready, must always be absorbed
- lsu_addr_i  in  5  destination FPR
- lsu_data_i  in  FLEN  load data
- fpu_valid_i  in  1  FPnew result with FP rd
- fpu_ready_o  out  1  FPU result accepted this cycle
- fpu_addr_i  in  5  destination FPR
- fpu_data_i  in  FLEN  result data
- vec_valid_i  in  1  Vicuna FPR write request
- vec_ready_o  out  1  Vicuna write accepted this cycle
- vec_addr_i  in  5  destination FPR
- vec_data_i  in  FLEN  data
- fpr_we_o  out  1  FPR write enable
- fpr_waddr_o  out  5  FPR write address
- fpr_wdata_o  out  FLEN  FPR write data
- fpr_wsrc_o  out  2  wb_src_e of the current write
- lsu_buf_cnt_o  out  $clog2(LSU_BUF_DEPTH+1)  FIFO occupancy, for the controller and debug

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO emptied; buffered entries are discarded.
  - starve_cnt_q = 0; rr_q = FPU.
- All outputs are combinational from state and inputs:
  - fpr_we_o, fpu_ready_o and vec_ready_o are 0 whenever no valid input is present and the FIFO is empty.
  - When rst_i is asserted, outputs still follow the comb logic; state is cleared at the edge.
- Zero latency: a grant writes the FPR in the same cycle. ready depends on valid; sources must not make valid depend on ready.
- Definitions:
  - lsu_pend = lsu_valid_i | (cnt != 0).
  - oth_pend = fpu_valid_i | vec_valid_i.
  - yield = oth_pend & (starve_cnt_q == STARVE_LIMIT) & (cnt < LSU_BUF_DEPTH).
- Grant selection, exactly one per cycle:
  - LSU class wins if lsu_pend & ~yield. It writes the FIFO head if cnt != 0, else bypasses lsu_* directly.
  - Otherwise, if oth_pend: the round-robin winner among FPU and VEC. If only one is valid, it wins. If both are valid, rr_q picks. rr_q flips to the other source after each FPU/VEC grant.
- FIFO push: lsu_valid_i & ~(LSU bypass granted).
  - Push and pop in the same cycle leave cnt unchanged.
  - Ordering: LSU writes retire in arrival order.
- Overflow is impossible by construction: yield requires cnt < DEPTH, and a full FIFO forces an LSU-class grant, which pops one entry while at most one is pushed. An assertion checks push & ~pop & (cnt == DEPTH) never occurs.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on an LSU-class grant while oth_pend.
  - Cleared on any FPU/VEC grant, or in any cycle with ~oth_pend.
- Same-address writes in one cycle are impossible: only one write per cycle. Successive writes to the same address apply in grant order.
- fpr_wsrc_o is valid only while fpr_we_o = 1.

Decomposition:
- fpu_ss_pkg gains:
  - typedef enum logic [1:0] wb_src_e {WbLsu=0, WbFpu=1, WbVec=2}.
  - struct fpr_wb_t {addr[4:0], data[FLEN-1:0]}.
- One sub-module: fpu_ss_wb_fifo, a parametric DEPTH FIFO of fpr_wb_t with push/pop/cnt and synchronous active-high reset.
- Arbitration, starvation counter and round-robin stay in the top module.

Test Plan:
- Solo sources: LSU {addr 3, data 0xA} in cycle 0 -> fpr_we_o=1, waddr 3, wsrc WbLsu in the same cycle, cnt 0. Repeat alone for FPU and for VEC -> ready=1 in the same cycle.
- Conflict: lsu_valid_i and fpu_valid_i held for 1 cycle, STARVE_LIMIT=4 -> LSU written; fpu_ready_o=0; FPU granted next cycle.
- Starvation: LSU valid every cycle for 10 cycles plus FPU valid, STARVE_LIMIT=4 -> cycles 0-3 grant LSU, cycle 4 grants FPU and LSU pushes (cnt=1), cycle 5 pops FIFO. The LSU write order equals issue order.
- Round-robin: FPU and VEC both valid for 4 cycles, no LSU -> grants FPU, VEC, FPU, VEC.
- Full FIFO: DEPTH=2, cnt=2, LSU + FPU valid at starve limit -> yield suppressed, LSU head written, cnt stays 2, no overflow assertion.
- Reset mid-operation: cnt=2, assert rst_i for 1 cycle -> cnt=0, starve_cnt 0, buffered writes never appear on the FPR port.
